// File: rtl/fft16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft16_pkg
// Description : Shared constants, serializer state type and the 4-bit
//               bit-reversal helper used by the 16-point FFT output path.
// Revision    : 1.0 - initial release
// ============================================================================
package fft16_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Reverse the four index bits: slot k of a radix-2 DIT output holds bin bitrev4(k)
    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft16_mag_sq.sv
`default_nettype none
// ============================================================================
// Module      : fft16_mag_sq
// Description : Squared magnitude re*re + im*im of one signed complex bin,
//               full precision, unsigned 2*WIDTH+1 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_mag_sq #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] i_re,
    input  logic signed [WIDTH-1:0] i_im,
    output logic [2*WIDTH:0]        o_mag
);

    // Sign-extend to the product width so each square is formed at full precision
    logic signed [2*WIDTH-1:0] w_re_ext;
    logic signed [2*WIDTH-1:0] w_im_ext;
    logic signed [2*WIDTH-1:0] w_sq_re;
    logic signed [2*WIDTH-1:0] w_sq_im;

    assign w_re_ext = {{WIDTH{i_re[WIDTH-1]}}, i_re};
    assign w_im_ext = {{WIDTH{i_im[WIDTH-1]}}, i_im};
    assign w_sq_re  = w_re_ext * w_re_ext;
    assign w_sq_im  = w_im_ext * w_im_ext;

    // Both squares are non-negative; the extra MSB absorbs the carry of
    // (-2^(W-1))^2 + (-2^(W-1))^2 = 2^(2W-1)
    assign o_mag = {1'b0, w_sq_re} + {1'b0, w_sq_im};

endmodule
`default_nettype wire

// File: rtl/fft16_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fft16_out_serializer
// Description : Snapshots 16 parallel complex FFT bins on a start strobe and
//               streams them one bin per beat, natural order, valid/ready.
//               Optional macro FFT16_MAG_SQ_EN enables the out_mag datapath
//               (re^2 + im^2); without it out_mag is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_out_serializer
    import fft16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit BITREV_IN = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [16*WIDTH-1:0]     yr_bus,
    input  logic [16*WIDTH-1:0]     yi_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic [3:0]              out_idx,
    output logic                    out_last,
    output logic [2*WIDTH:0]        out_mag,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    state_t                   r_state;
    logic [FFT_LOG2N-1:0]     r_idx;
    logic                     r_done;
    logic                     r_overrun;
    logic signed [WIDTH-1:0]  r_cap_re [FFT_N];
    logic signed [WIDTH-1:0]  r_cap_im [FFT_N];

    logic signed [WIDTH-1:0]  w_slot_re [FFT_N];
    logic signed [WIDTH-1:0]  w_slot_im [FFT_N];
    logic signed [WIDTH-1:0]  w_cur_re;
    logic signed [WIDTH-1:0]  w_cur_im;

    localparam logic [FFT_LOG2N-1:0] c_last_idx = FFT_LOG2N'(FFT_N - 1);

    // Route bus slots to capture registers, reordering to natural bin order when needed
    generate
        for (genvar n = 0; n < FFT_N; n++) begin : g_slot
            localparam int c_src = BITREV_IN ? int'(bitrev4(FFT_LOG2N'(n))) : n;
            assign w_slot_re[n] = yr_bus[c_src*WIDTH +: WIDTH];
            assign w_slot_im[n] = yi_bus[c_src*WIDTH +: WIDTH];
        end
    endgenerate

    // Control FSM: capture on start in IDLE, advance one bin per accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int n = 0; n < FFT_N; n++) begin
                r_cap_re[n] <= '0;
                r_cap_im[n] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_idx   <= '0;
                        for (int n = 0; n < FFT_N; n++) begin
                            r_cap_re[n] <= w_slot_re[n];
                            r_cap_im[n] <= w_slot_im[n];
                        end
                    end
                end
                STREAM: begin
                    // A start here (including on the final accept) cannot be honoured
                    if (start) begin
                        r_overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Current beat is read straight from the capture regs, so it holds while stalled
    assign w_cur_re  = r_cap_re[r_idx];
    assign w_cur_im  = r_cap_im[r_idx];

    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_re    = w_cur_re;
    assign out_im    = w_cur_im;
    assign out_idx   = r_idx;
    assign out_last  = (r_state == STREAM) && (r_idx == c_last_idx);
    assign done      = r_done;
    assign overrun   = r_overrun;

`ifdef FFT16_MAG_SQ_EN
    fft16_mag_sq #(
        .WIDTH (WIDTH)
    ) u_mag_sq (
        .i_re  (w_cur_re),
        .i_im  (w_cur_im),
        .o_mag (out_mag)
    );
`else
    assign out_mag = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft16_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft16_out_serializer
// Description : Self-checking bench for fft16_out_serializer. Two instances
//               (natural and bit-reversed input ordering) share stimulus; a
//               queue-based beat model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft16_out_serializer;

    localparam int W = 16;
    localparam int N = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             out_ready;
    logic [N*W-1:0]   yr_bus;
    logic [N*W-1:0]   yi_bus;

    logic             vld [2];
    logic             lst [2];
    logic             bsy [2];
    logic             dn  [2];
    logic             ovr [2];
    logic signed [W-1:0] ore [2];
    logic signed [W-1:0] oim [2];
    logic [3:0]       oidx [2];
    logic [2*W:0]     omag [2];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    typedef struct {
        int idx;
        int re_a;
        int im_a;
        int re_b;
        int im_b;
    } beat_t;

    beat_t q[$];
    bit    m_done = 1'b0;
    bit    m_ovr  = 1'b0;

    always #5 clk = ~clk;

    fft16_out_serializer #(.WIDTH(W), .BITREV_IN(1'b0)) u_dut_nat (
        .clk(clk), .rst(rst), .start(start), .yr_bus(yr_bus), .yi_bus(yi_bus),
        .out_valid(vld[0]), .out_ready(out_ready), .out_re(ore[0]), .out_im(oim[0]),
        .out_idx(oidx[0]), .out_last(lst[0]), .out_mag(omag[0]),
        .busy(bsy[0]), .done(dn[0]), .overrun(ovr[0])
    );

    fft16_out_serializer #(.WIDTH(W), .BITREV_IN(1'b1)) u_dut_rev (
        .clk(clk), .rst(rst), .start(start), .yr_bus(yr_bus), .yi_bus(yi_bus),
        .out_valid(vld[1]), .out_ready(out_ready), .out_re(ore[1]), .out_im(oim[1]),
        .out_idx(oidx[1]), .out_last(lst[1]), .out_mag(omag[1]),
        .busy(bsy[1]), .done(dn[1]), .overrun(ovr[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) r = r | (((k >> b) & 1) << (3 - b));
        return r;
    endfunction

    function automatic int slot_re(input int k);
        logic signed [W-1:0] v;
        v = yr_bus[k*W +: W];
        return int'(v);
    endfunction

    function automatic int slot_im(input int k);
        logic signed [W-1:0] v;
        v = yi_bus[k*W +: W];
        return int'(v);
    endfunction

    function automatic longint exp_mag(input int re, input int im);
`ifdef FFT16_MAG_SQ_EN
        return longint'(re) * longint'(re) + longint'(im) * longint'(im);
`else
        return 64'd0;
`endif
    endfunction

    // Behavioural model: a start while idle queues 16 beats; each accept pops one
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (q.size() != 0) begin
                if (start) m_ovr = 1'b1;
                if (out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                for (int n = 0; n < N; n++) begin
                    beat_t b;
                    b.idx  = n;
                    b.re_a = slot_re(n);
                    b.im_a = slot_im(n);
                    b.re_b = slot_re(brev(n));
                    b.im_b = slot_im(brev(n));
                    q.push_back(b);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("valid[%0d]", d), vld[d], q.size() != 0);
                chk($sformatf("busy[%0d]", d), bsy[d], q.size() != 0);
                chk($sformatf("done[%0d]", d), dn[d], m_done);
                chk($sformatf("overrun[%0d]", d), ovr[d], m_ovr);
                if (q.size() != 0) begin
                    beat_t h;
                    int er, ei;
                    h  = q[0];
                    er = (d == 0) ? h.re_a : h.re_b;
                    ei = (d == 0) ? h.im_a : h.im_b;
                    chk($sformatf("re[%0d]", d), ore[d], er);
                    chk($sformatf("im[%0d]", d), oim[d], ei);
                    chk($sformatf("idx[%0d]", d), oidx[d], h.idx);
                    chk($sformatf("last[%0d]", d), lst[d], h.idx == 15);
                    chk($sformatf("mag[%0d]", d), omag[d], exp_mag(er, ei));
                end else begin
                    chk($sformatf("last_idle[%0d]", d), lst[d], 1'b0);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            yr_bus[k*W +: W] = rnd_word();
            yi_bus[k*W +: W] = rnd_word();
        end
    endtask

    task automatic start_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        bit ok = 1'b0;
        for (int c = 0; c < 80 && !ok; c++) begin
            if (vld[0] && oidx[0] == 4'(target)) ok = 1'b1;
            else tick();
        end
        chk($sformatf("reach_idx_%0d", target), ok, 1'b1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int c = 0; c < 80 && !ok; c++) begin
            if (dn[0]) ok = 1'b1;
            else tick();
        end
        chk("done_seen", ok, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen5, acc, hold;
        bit fin;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; yr_bus = '0; yi_bus = '0;
        tick();
        tick();
        cmp_en = 1'b1;
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_valid", vld[0], 1'b0);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_done", dn[0], 1'b0);
        chk("rst_overrun", ovr[0], 1'b0);
        chk("rst_re", ore[0], 0);
        chk("rst_idx", oidx[0], 0);
        chk("rst_mag", omag[0], 0);

        // Impulse spectrum; bus scrambled after capture to prove the snapshot
        for (int k = 0; k < N; k++) begin
            yr_bus[k*W +: W] = 16'h7fff;
            yi_bus[k*W +: W] = '0;
        end
        out_ready = 1'b1;
        start_stream();
        fill_random();
        for (int i = 0; i < N; i++) begin
            chk("imp_valid", vld[0], 1'b1);
            chk("imp_idx", oidx[0], i);
            chk("imp_re", ore[0], 32767);
            chk("imp_im", oim[0], 0);
            chk("imp_last", lst[0], i == 15);
            tick();
        end
        chk("imp_done", dn[0], 1'b1);
        chk("imp_valid_off", vld[0], 1'b0);
        tick();
        chk("imp_done_pulse", dn[0], 1'b0);

        // Backpressure: ready low for 3 cycles while idx 5 is presented
        fill_random();
        start_stream();
        seen5 = 0; acc = 0; hold = 0; fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (dn[0]) fin = 1'b1;
            if (vld[0] && oidx[0] == 4'd5) begin
                seen5++;
                out_ready = (hold >= 3);
                if (hold < 3) hold++;
            end else begin
                out_ready = 1'b1;
            end
            if (vld[0] && out_ready) acc++;
            if (!fin) tick();
        end
        chk("bp_finished", fin, 1'b1);
        chk("bp_idx5_cycles", seen5, 4);
        chk("bp_beats", acc, 16);
        out_ready = 1'b1;
        tick();

        // Start while streaming at idx 7: ignored, overrun sticky until reset
        fill_random();
        start_stream();
        wait_idx(7);
        fill_random();
        start_stream();
        chk("ovr_set", ovr[0], 1'b1);
        wait_done();
        chk("ovr_sticky_after_done", ovr[0], 1'b1);
        tick();
        fill_random();
        start_stream();
        wait_done();
        chk("ovr_sticky_next_stream", ovr[0], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovr_cleared_by_rst", ovr[0], 1'b0);
        tick();

        // Reset at idx 9 aborts without done; fresh start begins at idx 0
        fill_random();
        start_stream();
        wait_idx(9);
        rst = 1'b1;
        tick();
        chk("abort_valid", vld[0], 1'b0);
        chk("abort_busy", bsy[0], 1'b0);
        chk("abort_idx", oidx[0], 0);
        chk("abort_done", dn[0], 1'b0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", dn[0], 1'b0);
        fill_random();
        start_stream();
        chk("fresh_valid", vld[0], 1'b1);
        chk("fresh_idx", oidx[0], 0);
        wait_done();
        tick();

        // Bit-reversed input: slot 1 lands on bin 8
        yr_bus = '0;
        yi_bus = '0;
        yr_bus[1*W +: W] = 16'd100;
        start_stream();
        for (int i = 0; i < N; i++) begin
            chk("brev_nat_re", ore[0], (i == 1) ? 100 : 0);
            chk("brev_rev_re", ore[1], (i == 8) ? 100 : 0);
            tick();
        end
        chk("brev_done", dn[1], 1'b1);
        tick();

        // Start coinciding with the final accept is ignored and flags overrun
        fill_random();
        start_stream();
        wait_idx(15);
        start_stream();
        chk("late_start_ovr", ovr[0], 1'b1);
        chk("late_start_done", dn[0], 1'b1);
        chk("late_start_valid", vld[0], 1'b0);
        tick();
        chk("late_start_no_restart", vld[0], 1'b0);

`ifdef FFT16_MAG_SQ_EN
        // Squared magnitude at nominal and extreme values
        yr_bus = '0;
        yi_bus = '0;
        yr_bus[3*W +: W] = 16'd3;
        yi_bus[3*W +: W] = 16'd4;
        yr_bus[5*W +: W] = 16'h8000;
        yi_bus[5*W +: W] = 16'h8000;
        start_stream();
        wait_idx(3);
        chk("mag_3_4", omag[0], 25);
        wait_idx(5);
        chk("mag_min_min", omag[0], 64'd2147483648);
        wait_done();
        tick();
`endif

        // Randomized traffic: random data, ready, start pulses and rare resets
        for (int c = 0; c < 1500; c++) begin
            fill_random();
            out_ready = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
